// File: rtl/addsub_pkg.sv
// addsub_pkg: op and state encodings shared by the add/subtract unit
package addsub_pkg;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_ADC = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_SBC = 2'b11;
  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;
endpackage

// File: rtl/addsub_seq_if.sv
// addsub_seq_if: operand/result handshake bundle of the add/subtract unit
interface addsub_seq_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [WIDTH-1:0] in_data0;
  logic [WIDTH-1:0] in_data1;
  logic             in_carry;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_negative;
  logic             out_zero;
  logic             out_carry;
  logic             out_overflow;
  modport master (
    output in_valid, in_op, in_data0, in_data1, in_carry, out_ready,
    input  in_ready, out_valid, out_data, out_negative, out_zero, out_carry, out_overflow
  );
  modport slave (
    input  in_valid, in_op, in_data0, in_data1, in_carry, out_ready,
    output in_ready, out_valid, out_data, out_negative, out_zero, out_carry, out_overflow
  );
endinterface

// File: rtl/addsub_chunk.sv
// addsub_chunk: one CHUNK-wide adder slice, also exposing the carry into its MSB
module addsub_chunk #(parameter int CHUNK = 8) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             cmsb
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
  assign cmsb = sum[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];
endmodule

// File: rtl/addsub_seq.sv
// addsub_seq: multi-cycle ADD/ADC/SUB/SBC unit, CHUNK bits per cycle with NZCV flags
module addsub_seq
  import addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input logic         clk,
  input logic         rst_n,
  input logic         in_clear,
  addsub_seq_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);
  state_t           state;
  logic [WIDTH-1:0] a_q, b_q, res;
  logic [CW-1:0]    cnt;
  logic             carry, nz, n_q, z_q, c_q, v_q, c0, cout, cmsb;
  logic [CHUNK-1:0] sum;
  assign c0 = bus.in_op == OP_ADD ? 1'b0 : bus.in_op == OP_SUB ? 1'b1 : bus.in_carry;
  addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a    (a_q[int'(cnt)*CHUNK +: CHUNK]),
    .b    (b_q[int'(cnt)*CHUNK +: CHUNK]),
    .cin  (carry),
    .sum  (sum),
    .cout (cout),
    .cmsb (cmsb)
  );
  // subtraction is folded into the latch: B is stored already inverted
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_IDLE;
      a_q   <= '0;
      b_q   <= '0;
      res   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      nz    <= 1'b0;
      n_q   <= 1'b0;
      z_q   <= 1'b0;
      c_q   <= 1'b0;
      v_q   <= 1'b0;
    end else if (in_clear) begin
      state <= ST_IDLE;
    end else if (state == ST_IDLE && bus.in_valid) begin
      a_q   <= bus.in_data0;
      b_q   <= bus.in_op[1] ? ~bus.in_data1 : bus.in_data1;
      carry <= c0;
      res   <= '0;
      nz    <= 1'b0;
      cnt   <= '0;
      state <= ST_BUSY;
    end else if (state == ST_BUSY) begin
      res[int'(cnt)*CHUNK +: CHUNK] <= sum;
      carry <= cout;
      nz    <= nz | (|sum);
      cnt   <= cnt == LAST ? '0 : cnt + 1'b1;
      if (cnt == LAST) begin
        n_q   <= sum[CHUNK-1];
        z_q   <= ~(nz | (|sum));
        c_q   <= cout;
        v_q   <= cout ^ cmsb;
        state <= ST_DONE;
      end
    end else if (state == ST_DONE && bus.out_ready) begin
      state <= ST_IDLE;
    end
  assign bus.in_ready     = state == ST_IDLE;
  assign bus.out_valid    = state == ST_DONE;
  assign bus.out_data     = res;
  assign bus.out_negative = n_q;
  assign bus.out_zero     = z_q;
  assign bus.out_carry    = c_q;
  assign bus.out_overflow = v_q;
endmodule

// File: tb/tb_addsub_seq.sv
// tb_addsub_seq: directed and randomized checks of addsub_seq in three width/chunk configurations
module tb_addsub_seq;
  import addsub_pkg::*;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        clr [3];
  logic        v [3];
  logic        rdy [3];
  logic        cin [3];
  logic [1:0]  op [3];
  logic [63:0] d0 [3];
  logic [63:0] d1 [3];
  logic        ir [3];
  logic        ov [3];
  logic        fn [3];
  logic        fz [3];
  logic        fc [3];
  logic        fv [3];
  logic [63:0] od [3];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  addsub_seq_if #(.WIDTH(32)) b0 ();
  addsub_seq_if #(.WIDTH(64)) b1 ();
  addsub_seq_if #(.WIDTH(32)) b2 ();
  assign b0.in_valid = v[0];  assign b0.in_op = op[0];  assign b0.in_carry = cin[0];  assign b0.out_ready = rdy[0];
  assign b0.in_data0 = d0[0][31:0];  assign b0.in_data1 = d1[0][31:0];
  assign ir[0] = b0.in_ready;  assign ov[0] = b0.out_valid;  assign od[0] = {32'b0, b0.out_data};
  assign fn[0] = b0.out_negative;  assign fz[0] = b0.out_zero;  assign fc[0] = b0.out_carry;  assign fv[0] = b0.out_overflow;
  assign b1.in_valid = v[1];  assign b1.in_op = op[1];  assign b1.in_carry = cin[1];  assign b1.out_ready = rdy[1];
  assign b1.in_data0 = d0[1];  assign b1.in_data1 = d1[1];
  assign ir[1] = b1.in_ready;  assign ov[1] = b1.out_valid;  assign od[1] = b1.out_data;
  assign fn[1] = b1.out_negative;  assign fz[1] = b1.out_zero;  assign fc[1] = b1.out_carry;  assign fv[1] = b1.out_overflow;
  assign b2.in_valid = v[2];  assign b2.in_op = op[2];  assign b2.in_carry = cin[2];  assign b2.out_ready = rdy[2];
  assign b2.in_data0 = d0[2][31:0];  assign b2.in_data1 = d1[2][31:0];
  assign ir[2] = b2.in_ready;  assign ov[2] = b2.out_valid;  assign od[2] = {32'b0, b2.out_data};
  assign fn[2] = b2.out_negative;  assign fz[2] = b2.out_zero;  assign fc[2] = b2.out_carry;  assign fv[2] = b2.out_overflow;
  addsub_seq #(.WIDTH(32), .CHUNK(8))  u0 (.clk(clk), .rst_n(rst_n), .in_clear(clr[0]), .bus(b0));
  addsub_seq #(.WIDTH(64), .CHUNK(16)) u1 (.clk(clk), .rst_n(rst_n), .in_clear(clr[1]), .bus(b1));
  addsub_seq #(.WIDTH(32), .CHUNK(32)) u2 (.clk(clk), .rst_n(rst_n), .in_clear(clr[2]), .bus(b2));

  // Reference: whole-word arithmetic from the op rules, flags as {N,Z,C,V}
  function automatic void model(input int w, input logic [1:0] o, input logic [63:0] a, input logic [63:0] b,
                                input logic ci, output logic [63:0] r, output logic [3:0] f);
    logic [63:0] m, am, bm;
    logic [64:0] s;
    logic        c, c0;
    m  = w == 64 ? '1 : 64'h0000_0000_FFFF_FFFF;
    am = a & m;
    bm = (o == OP_SUB || o == OP_SBC ? ~b : b) & m;
    c0 = o == OP_ADD ? 1'b0 : o == OP_SUB ? 1'b1 : ci;
    s  = {1'b0, am} + {1'b0, bm} + {64'b0, c0};
    r  = s[63:0] & m;
    c  = w == 64 ? s[64] : s[32];
    f  = {r[w-1], r == 64'd0, c, (am[w-1] == bm[w-1]) && (r[w-1] != am[w-1])};
  endfunction

  task automatic start_op(input int k, input logic [1:0] o, input logic [63:0] a, input logic [63:0] b, input logic ci);
    int t = 0;
    while (!ir[k] && t < 50) begin @(negedge clk); t++; end
    if (t == 50) begin
      checks++; errors++;
      $display("FAIL accept_u%0d: in_ready=%0b after %0d cycles, expected 1", k, ir[k], t);
    end
    op[k] = o; d0[k] = a; d1[k] = b; cin[k] = ci; v[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v[k] = 1'b0; op[k] = 2'($urandom); d0[k] = {$urandom, $urandom}; d1[k] = {$urandom, $urandom}; cin[k] = 1'($urandom);
  endtask

  task automatic wait_done(input int k, output int lat);
    lat = 0;
    while (!ov[k] && lat < 40) begin @(negedge clk); lat++; end
  endtask

  task automatic finish_op(input int k);
    rdy[k] = 1'b1;
    @(negedge clk);
    rdy[k] = 1'b0;
  endtask

  task automatic test_reset;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({ir[k], ov[k], od[k], fn[k], fz[k], fc[k], fv[k]} !== {1'b1, 1'b0, 64'd0, 4'b0000}) begin
        errors++;
        $display("FAIL reset_u%0d: ready=%0b valid=%0b data=%h nzcv=%b, expected 1 0 0 0000",
                 k, ir[k], ov[k], od[k], {fn[k], fz[k], fc[k], fv[k]});
      end
    end
  endtask

  typedef struct packed {
    logic [1:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic [31:0] r;
    logic [3:0]  f;
  } vec_t;

  task automatic test_directed;
    vec_t tv [9];
    int   lat;
    tv[0] = '{OP_SUB, 32'd5,          32'd3, 1'b0, 32'd2,          4'b0010};
    tv[1] = '{OP_SUB, 32'd3,          32'd5, 1'b0, 32'hFFFF_FFFE,  4'b1000};
    tv[2] = '{OP_SUB, 32'h8000_0000,  32'd1, 1'b0, 32'h7FFF_FFFF,  4'b0011};
    tv[3] = '{OP_ADD, 32'hFFFF_FFFF,  32'd1, 1'b0, 32'd0,          4'b0110};
    tv[4] = '{OP_ADC, 32'h7FFF_FFFF,  32'd0, 1'b1, 32'h8000_0000,  4'b1001};
    tv[5] = '{OP_SBC, 32'd5,          32'd3, 1'b0, 32'd1,          4'b0010};
    tv[6] = '{OP_SUB, 32'd5,          32'd5, 1'b0, 32'd0,          4'b0110};
    tv[7] = '{OP_SBC, 32'd5,          32'd3, 1'b1, 32'd2,          4'b0010};
    tv[8] = '{OP_ADD, 32'd1,          32'd1, 1'b1, 32'd2,          4'b0000};
    foreach (tv[i]) begin
      start_op(0, tv[i].o, 64'(tv[i].a), 64'(tv[i].b), tv[i].ci);
      wait_done(0, lat);
      checks++;
      if (lat != 4) begin
        errors++;
        $display("FAIL dir%0d_latency: got %0d cycles, expected 4", i, lat);
      end
      checks++;
      if (od[0] !== 64'(tv[i].r) || {fn[0], fz[0], fc[0], fv[0]} !== tv[i].f) begin
        errors++;
        $display("FAIL dir%0d_result: data=%h nzcv=%b, expected data=%h nzcv=%b",
                 i, od[0], {fn[0], fz[0], fc[0], fv[0]}, tv[i].r, tv[i].f);
      end
      finish_op(0);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    start_op(0, OP_ADD, 64'h1111_2222, 64'h0000_0003, 1'b0);
    wait_done(0, lat);
    op[0] = OP_SUB; d0[0] = 64'd100; d1[0] = 64'd58; cin[0] = 1'b0; v[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (!ov[0] || ir[0] || od[0] !== 64'h1111_2225) begin
        errors++;
        $display("FAIL stall%0d: valid=%0b ready=%0b data=%h, expected 1 0 00000000_11112225", i, ov[0], ir[0], od[0]);
      end
    end
    rdy[0] = 1'b1;
    @(negedge clk);
    rdy[0] = 1'b0;
    checks++;
    if (!ir[0] || ov[0]) begin
      errors++;
      $display("FAIL handshake_idle: ready=%0b valid=%0b, expected 1 0", ir[0], ov[0]);
    end
    @(posedge clk);
    @(negedge clk);
    v[0] = 1'b0; d0[0] = '1; d1[0] = '1;
    wait_done(0, lat);
    checks++;
    if (lat != 4 || od[0] !== 64'd42 || {fn[0], fz[0], fc[0], fv[0]} !== 4'b0010) begin
      errors++;
      $display("FAIL second_op: lat=%0d data=%h nzcv=%b, expected 4 42 0010", lat, od[0], {fn[0], fz[0], fc[0], fv[0]});
    end
    finish_op(0);
  endtask

  task automatic test_reset_busy;
    int lat;
    start_op(0, OP_SUB, 64'h1234_5678, 64'd1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ir[0], ov[0], od[0], fn[0], fz[0], fc[0], fv[0]} !== {1'b1, 1'b0, 64'd0, 4'b0000}) begin
      errors++;
      $display("FAIL async_reset: ready=%0b valid=%0b data=%h nzcv=%b, expected 1 0 0 0000",
               ir[0], ov[0], od[0], {fn[0], fz[0], fc[0], fv[0]});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_op(0, OP_SUB, 64'd10, 64'd4, 1'b0);
    wait_done(0, lat);
    checks++;
    if (lat != 4 || od[0] !== 64'd6 || {fn[0], fz[0], fc[0], fv[0]} !== 4'b0010) begin
      errors++;
      $display("FAIL after_reset: lat=%0d data=%h nzcv=%b, expected 4 6 0010", lat, od[0], {fn[0], fz[0], fc[0], fv[0]});
    end
    finish_op(0);
  endtask

  task automatic test_clear;
    int lat;
    logic seen = 1'b0;
    start_op(0, OP_ADD, 64'd1, 64'd2, 1'b0);
    @(negedge clk);
    clr[0] = 1'b1;
    @(negedge clk);
    clr[0] = 1'b0;
    checks++;
    if (!ir[0] || ov[0]) begin
      errors++;
      $display("FAIL clear_busy: ready=%0b valid=%0b, expected 1 0", ir[0], ov[0]);
    end
    repeat (6) begin @(negedge clk); seen |= ov[0]; end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL clear_no_valid: out_valid rose after clear, expected it to stay 0");
    end
    start_op(0, OP_ADD, 64'd7, 64'd8, 1'b0);
    wait_done(0, lat);
    clr[0] = 1'b1;
    @(negedge clk);
    clr[0] = 1'b0;
    checks++;
    if (!ir[0] || ov[0] || od[0] !== 64'd15) begin
      errors++;
      $display("FAIL clear_done: ready=%0b valid=%0b data=%h, expected 1 0 15", ir[0], ov[0], od[0]);
    end
  endtask

  task automatic test_random(input int k, input int w, input int lat_exp, input int n);
    logic [63:0] a, b, r;
    logic [1:0]  o;
    logic        ci;
    logic [3:0]  f;
    int          lat;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      o = 2'($urandom); a = {$urandom, $urandom}; b = {$urandom, $urandom}; ci = 1'($urandom);
      if ($urandom_range(0, 7) == 0) b = a;
      if ($urandom_range(0, 7) == 0) a = '1;
      if ($urandom_range(0, 7) == 0) b = '0;
      model(w, o, a, b, ci, r, f);
      start_op(k, o, a, b, ci);
      rdy[k] = 1'($urandom);
      wait_done(k, lat);
      rdy[k] = 1'b0;
      checks++;
      if (lat != lat_exp || od[k] !== r || {fn[k], fz[k], fc[k], fv[k]} !== f) begin
        errors++;
        $display("FAIL rand_u%0d_%0d op=%0d a=%h b=%h c=%0b: lat=%0d data=%h nzcv=%b, expected lat=%0d data=%h nzcv=%b",
                 k, i, o, a, b, ci, lat, od[k], {fn[k], fz[k], fc[k], fv[k]}, lat_exp, r, f);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      checks++;
      if (!ov[k] || ir[k] || od[k] !== r) begin
        errors++;
        $display("FAIL rand_hold_u%0d_%0d: valid=%0b ready=%0b data=%h, expected 1 0 %h", k, i, ov[k], ir[k], od[k], r);
      end
      finish_op(k);
      checks++;
      if (ov[k] || !ir[k]) begin
        errors++;
        $display("FAIL rand_release_u%0d_%0d: valid=%0b ready=%0b, expected 0 1", k, i, ov[k], ir[k]);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      clr[k] = 1'b0; v[k] = 1'b0; rdy[k] = 1'b0; cin[k] = 1'b0; op[k] = 2'b00; d0[k] = '0; d1[k] = '0;
    end
    #1 rst_n = 1'b0;
    @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    @(negedge clk);
    test_directed;
    test_back_to_back;
    test_reset_busy;
    test_clear;
    test_random(0, 32, 4, 1500);
    test_random(1, 64, 4, 1500);
    test_random(2, 32, 1, 1500);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
